// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: combination-lock controller fed by the keypad scanner.
//   Collects digit entries, compares them with a volatile stored code, and
//   handles code changes while unlocked, a failed-attempt lockout and auto-relock.
// Ports:
//   MAX10_CLK1_50   system clock (50 MHz)
//   rst             asynchronous, active-low reset
//   key_code        scanner key: 0-9 digits, A-D letters, E enter, F clear
//   key_validn      low while a key is held; key_code stable while low
//   unlocked        high in UNLOCKED / PROG_NEW / PROG_CONFIRM
//   lockout_active  high in LOCKOUT
//   prog_mode       high in PROG_NEW / PROG_CONFIRM
//   entry_digits    digits entered so far, newest in [3:0], zero-filled
//   entry_count     number of digits held in entry_digits
//   fail_count      consecutive failed attempts
//   ok_pulse        one-cycle strobe: correct code or successful code change
//   err_pulse       one-cycle strobe: wrong code, overflow digit, failed programming
module combo_lock_ctrl #(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned           MAX_FAILS      = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned           UNLOCK_CYCLES  = 1_500_000_000
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  rst,
  input  logic [3:0]            key_code,
  input  logic                  key_validn,
  output logic                  unlocked,
  output logic                  lockout_active,
  output logic                  prog_mode,
  output logic [4*CODE_LEN-1:0] entry_digits,
  output logic [2:0]            entry_count,
  output logic [2:0]            fail_count,
  output logic                  ok_pulse,
  output logic                  err_pulse
);

  localparam int unsigned DW         = 4 * CODE_LEN;
  localparam logic [2:0]  FULL_COUNT = 3'(CODE_LEN);
  localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAILS);
  localparam logic [31:0] LOCK_T     = 32'(LOCKOUT_CYCLES);
  localparam logic [31:0] UNL_T      = 32'(UNLOCK_CYCLES);

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [2:0] S_LOCKED       = 3'd0;
  localparam logic [2:0] S_ENTRY        = 3'd1;
  localparam logic [2:0] S_CHECK        = 3'd2;
  localparam logic [2:0] S_UNLOCKED     = 3'd3;
  localparam logic [2:0] S_PROG_NEW     = 3'd4;
  localparam logic [2:0] S_PROG_CONFIRM = 3'd5;
  localparam logic [2:0] S_LOCKOUT      = 3'd6;

  logic          valid_meta_r, valid_sync_r, valid_prev_r;
  logic [3:0]    code_meta_r, code_sync_r;
  logic [2:0]    state_r, state_nxt_s;
  logic [DW-1:0] code_r, code_nxt_s, new_code_r, new_code_nxt_s;
  logic [31:0]   timer_r, timer_nxt_s, timer_dec_s;
  logic [DW-1:0] digits_nxt_s, dig_digits_s;
  logic [2:0]    count_nxt_s, dig_count_s, fail_nxt_s;
  logic          ok_nxt_s, err_nxt_s, dig_err_s;
  logic          press_s, digit_s, entry_full_s, expire_s;

  // Two-flop synchronisers for the scanner inputs plus previous-valid flop for edge detect
  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      valid_meta_r <= 1'b1;
      valid_sync_r <= 1'b1;
      valid_prev_r <= 1'b1;
      code_meta_r  <= 4'hF;
      code_sync_r  <= 4'hF;
    end else begin
      valid_meta_r <= key_validn;
      valid_sync_r <= valid_meta_r;
      valid_prev_r <= valid_sync_r;
      code_meta_r  <= key_code;
      code_sync_r  <= code_meta_r;
    end
  end

  // Press detection and the shared digit-append result used by all entry states
  always_comb begin
    press_s      = valid_prev_r & ~valid_sync_r;
    digit_s      = press_s && (code_sync_r <= 4'd9);
    entry_full_s = (entry_count == FULL_COUNT);
    timer_dec_s  = (timer_r != 32'd0) ? (timer_r - 32'd1) : 32'd0;
    // Auto-relock is disabled entirely when UNLOCK_CYCLES is zero
    expire_s     = (UNL_T != 32'd0) && (timer_r == 32'd1);
    if (entry_full_s) begin
      dig_digits_s = entry_digits;
      dig_count_s  = entry_count;
      dig_err_s    = 1'b1;
    end else begin
      dig_digits_s = (entry_digits << 3'd4) | DW'(code_sync_r);
      dig_count_s  = entry_count + 3'd1;
      dig_err_s    = 1'b0;
    end
  end

  // Next-state, entry, code, timer and pulse computation
  always_comb begin
    state_nxt_s    = state_r;
    digits_nxt_s   = entry_digits;
    count_nxt_s    = entry_count;
    fail_nxt_s     = fail_count;
    code_nxt_s     = code_r;
    new_code_nxt_s = new_code_r;
    timer_nxt_s    = timer_dec_s;
    ok_nxt_s       = 1'b0;
    err_nxt_s      = 1'b0;
    case (state_r)
      S_LOCKED: begin
        if (digit_s) begin
          digits_nxt_s = DW'(code_sync_r);
          count_nxt_s  = 3'd1;
          state_nxt_s  = S_ENTRY;
        end else begin
          state_nxt_s = S_LOCKED;
        end
      end
      S_ENTRY: begin
        if (digit_s) begin
          digits_nxt_s = dig_digits_s;
          count_nxt_s  = dig_count_s;
          err_nxt_s    = dig_err_s;
        end else if (press_s && code_sync_r == KEY_E) begin
          state_nxt_s = S_CHECK;
        end else if (press_s && code_sync_r == KEY_F) begin
          digits_nxt_s = '0;
          count_nxt_s  = 3'd0;
          state_nxt_s  = S_LOCKED;
        end else begin
          state_nxt_s = S_ENTRY;
        end
      end
      // Presses landing here are consumed by the edge detector and dropped
      S_CHECK: begin
        digits_nxt_s = '0;
        count_nxt_s  = 3'd0;
        if (entry_full_s && entry_digits == code_r) begin
          ok_nxt_s    = 1'b1;
          fail_nxt_s  = 3'd0;
          timer_nxt_s = UNL_T;
          state_nxt_s = S_UNLOCKED;
        end else begin
          err_nxt_s  = 1'b1;
          fail_nxt_s = fail_count + 3'd1;
          if (fail_count + 3'd1 == FAIL_LIMIT) begin
            timer_nxt_s = LOCK_T;
            state_nxt_s = S_LOCKOUT;
          end else begin
            state_nxt_s = S_LOCKED;
          end
        end
      end
      S_UNLOCKED: begin
        if (press_s) begin
          timer_nxt_s = UNL_T;
          if (code_sync_r == KEY_B) begin
            timer_nxt_s = 32'd0;
            state_nxt_s = S_LOCKED;
          end else if (code_sync_r == KEY_A) begin
            digits_nxt_s = '0;
            count_nxt_s  = 3'd0;
            state_nxt_s  = S_PROG_NEW;
          end else begin
            state_nxt_s = S_UNLOCKED;
          end
        end else if (expire_s) begin
          state_nxt_s = S_LOCKED;
        end else begin
          state_nxt_s = S_UNLOCKED;
        end
      end
      S_PROG_NEW, S_PROG_CONFIRM: begin
        if (press_s) begin
          timer_nxt_s = UNL_T;
          if (digit_s) begin
            digits_nxt_s = dig_digits_s;
            count_nxt_s  = dig_count_s;
            err_nxt_s    = dig_err_s;
          end else if (code_sync_r == KEY_E) begin
            digits_nxt_s = '0;
            count_nxt_s  = 3'd0;
            if (state_r == S_PROG_NEW) begin
              if (entry_full_s) begin
                new_code_nxt_s = entry_digits;
                state_nxt_s    = S_PROG_CONFIRM;
              end else begin
                err_nxt_s = 1'b1;
              end
            end else begin
              state_nxt_s = S_UNLOCKED;
              if (entry_full_s && entry_digits == new_code_r) begin
                code_nxt_s = new_code_r;
                ok_nxt_s   = 1'b1;
              end else begin
                err_nxt_s = 1'b1;
              end
            end
          end else if (code_sync_r == KEY_F) begin
            digits_nxt_s = '0;
            count_nxt_s  = 3'd0;
            state_nxt_s  = S_UNLOCKED;
          end else begin
            state_nxt_s = state_r;
          end
        end else if (expire_s) begin
          // Relock discards any half-finished programming
          digits_nxt_s = '0;
          count_nxt_s  = 3'd0;
          state_nxt_s  = S_LOCKED;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_LOCKOUT: begin
        if (timer_r <= 32'd1) begin
          fail_nxt_s  = 3'd0;
          timer_nxt_s = 32'd0;
          state_nxt_s = S_LOCKED;
        end else begin
          state_nxt_s = S_LOCKOUT;
        end
      end
      default: begin
        digits_nxt_s = '0;
        count_nxt_s  = 3'd0;
        timer_nxt_s  = 32'd0;
        state_nxt_s  = S_LOCKED;
      end
    endcase
  end

  // State, stored code and registered outputs; status flags decode the next state
  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      state_r        <= S_LOCKED;
      code_r         <= DEFAULT_CODE;
      new_code_r     <= '0;
      timer_r        <= 32'd0;
      entry_digits   <= '0;
      entry_count    <= 3'd0;
      fail_count     <= 3'd0;
      ok_pulse       <= 1'b0;
      err_pulse      <= 1'b0;
      unlocked       <= 1'b0;
      lockout_active <= 1'b0;
      prog_mode      <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      code_r         <= code_nxt_s;
      new_code_r     <= new_code_nxt_s;
      timer_r        <= timer_nxt_s;
      entry_digits   <= digits_nxt_s;
      entry_count    <= count_nxt_s;
      fail_count     <= fail_nxt_s;
      ok_pulse       <= ok_nxt_s;
      err_pulse      <= err_nxt_s;
      unlocked       <= (state_nxt_s == S_UNLOCKED) || (state_nxt_s == S_PROG_NEW) ||
                        (state_nxt_s == S_PROG_CONFIRM);
      lockout_active <= (state_nxt_s == S_LOCKOUT);
      prog_mode      <= (state_nxt_s == S_PROG_NEW) || (state_nxt_s == S_PROG_CONFIRM);
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: directed scoreboard bench for combo_lock_ctrl.
//   The stimulus process queues the expected output snapshot for every
//   ok/err strobe, and queues probe snapshots for quiet-state checks; a
//   monitor process owns the comparison and failure counters.
module tb_combo_lock_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_validn;
  logic        unlocked, lockout_active, prog_mode, ok_pulse, err_pulse;
  logic [15:0] entry_digits;
  logic [2:0]  entry_count, fail_count;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic        unl;
    logic        lko;
    logic        prg;
    logic [2:0]  fail;
    logic [2:0]  cnt;
    logic [15:0] dig;
  } snap_t;

  snap_t pulse_q[$];
  string pulse_name_q[$];
  snap_t probe_q[$];
  string probe_name_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  logic  done  = 1'b0;

  combo_lock_ctrl #(
    .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .MAX_FAILS(3),
    .LOCKOUT_CYCLES(100), .UNLOCK_CYCLES(200)
  ) dut (
    .MAX10_CLK1_50(clk), .rst(rst), .key_code(key_code), .key_validn(key_validn),
    .unlocked(unlocked), .lockout_active(lockout_active), .prog_mode(prog_mode),
    .entry_digits(entry_digits), .entry_count(entry_count), .fail_count(fail_count),
    .ok_pulse(ok_pulse), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input logic ok, input logic err, input logic unl,
                               input logic lko, input logic prg, input logic [2:0] fail,
                               input logic [2:0] cnt, input logic [15:0] dig);
    mk = {ok, err, unl, lko, prg, fail, cnt, dig};
  endfunction

  // Monitor: sole owner of the counters; compares strobes and probes on the falling edge
  always @(negedge clk) begin
    snap_t act;
    snap_t exp_s;
    string nm;
    act = {ok_pulse, err_pulse, unlocked, lockout_active, prog_mode,
           fail_count, entry_count, entry_digits};
    if (rst && (ok_pulse || err_pulse)) begin
      n_cmp++;
      if (pulse_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_pulse got=%h want=no strobe", act);
      end else begin
        exp_s = pulse_q.pop_front();
        nm    = pulse_name_q.pop_front();
        if (act !== exp_s) begin
          n_mis++;
          $display("FAIL %s got=%h want=%h", nm, act, exp_s);
        end
      end
    end
    if (probe_q.size() != 0) begin
      exp_s = probe_q.pop_front();
      nm    = probe_name_q.pop_front();
      n_cmp++;
      if (act !== exp_s) begin
        n_mis++;
        $display("FAIL %s got=%h want=%h", nm, act, exp_s);
      end
    end
    if (done) begin
      n_cmp++;
      if (pulse_q.size() != 0) begin
        n_mis++;
        $display("FAIL missing_pulses got=0 want=%0d outstanding", pulse_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
    end
  end

  task automatic expect_pulse(input string nm, input snap_t s);
    pulse_q.push_back(s);
    pulse_name_q.push_back(nm);
  endtask

  task automatic probe(input string nm, input snap_t s);
    probe_q.push_back(s);
    probe_name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code   = k;
    key_validn = 1'b0;
    repeat (4) @(negedge clk);
    key_validn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Presses n keys taken from s, most significant nibble first
  task automatic keys(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) press(s[4*(n-1-i) +: 4]);
  endtask

  initial begin
    rst        = 1'b0;
    key_code   = 4'hF;
    key_validn = 1'b1;
    repeat (3) @(negedge clk);
    probe("reset_state", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Correct default code
    expect_pulse("unlock_default", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h1234E, 5);
    press(4'hB);
    probe("relock_b", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));

    // Three wrong attempts into lockout
    expect_pulse("wrong_1", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 16'h0000));
    keys(32'h1235E, 5);
    expect_pulse("wrong_2", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 16'h0000));
    keys(32'h1235E, 5);
    expect_pulse("wrong_3", mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h0000));
    keys(32'h1235E, 5);
    probe("lockout_on", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h0000));
    keys(32'h1234E, 5);
    probe("lockout_ignores", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 16'h0000));
    repeat (60) @(negedge clk);
    probe("lockout_end", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    expect_pulse("unlock_after_lockout", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h1234E, 5);
    press(4'hB);

    // Fifth digit overflows, then clear
    expect_pulse("overflow_digit", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 16'h1234));
    keys(32'h12345, 5);
    press(4'hF);
    probe("clear_f", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));

    // Long hold yields exactly one digit
    @(negedge clk);
    key_code   = 4'h7;
    key_validn = 1'b0;
    repeat (1000) @(negedge clk);
    key_validn = 1'b1;
    repeat (4) @(negedge clk);
    probe("hold_one_digit", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 16'h0007));
    press(4'hF);

    // Change the code to 9876
    expect_pulse("unlock_for_prog", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h1234E, 5);
    press(4'hA);
    probe("prog_new", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0000));
    keys(32'h9876E, 5);
    probe("prog_confirm", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0000));
    expect_pulse("prog_ok", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h9876E, 5);
    press(4'hB);
    probe("locked_after_prog", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    expect_pulse("new_code_unlocks", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h9876E, 5);
    press(4'hB);
    expect_pulse("old_code_fails", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 16'h0000));
    keys(32'h1234E, 5);

    // Reset while in PROG_CONFIRM restores the default code
    expect_pulse("unlock_9876", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h9876E, 5);
    press(4'hA);
    keys(32'h5555E, 5);
    probe("confirm_before_reset", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0000));
    rst = 1'b0;
    probe("mid_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    expect_pulse("code_restored", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h1234E, 5);

    // Mismatched confirmation keeps the old code
    press(4'hA);
    keys(32'h5555E, 5);
    expect_pulse("confirm_mismatch", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h5554E, 5);
    press(4'hB);
    expect_pulse("code_kept", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    keys(32'h1234E, 5);

    // Auto-relock after 200 idle cycles
    repeat (190) @(negedge clk);
    probe("still_unlocked", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));
    repeat (10) @(negedge clk);
    probe("auto_relock", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000));

    done = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
